// File: rtl/drive_arbiter.sv
// drive_arbiter: decides which command source owns the wheels (tracer, Bluetooth remote,
// obstacle manoeuvres). Define AVOID_EN to build the BACKUP/TURN obstacle avoidance states.
module drive_arbiter #(
  parameter int unsigned BACKUP_CYCLES = 25000000,
  parameter int unsigned TURN_CYCLES   = 20000000,
  parameter int unsigned REMOTE_HOLD   = 50000000,
  parameter int unsigned CNT_W         = 27
) (
  input  logic       clk,
  input  logic       CR,
  input  logic       En_Tracing,
  input  logic [1:0] trace_cmd,
  input  logic       rc_valid,
  input  logic [2:0] rc_cmd,
  input  logic [1:0] AvoidSignal,
  output logic [1:0] Control_Wheel_1,
  output logic [1:0] Control_Wheel_2,
  output logic [1:0] spd_sel_1,
  output logic [1:0] spd_sel_2,
  output logic [3:0] Led_Direction,
  output logic [2:0] mode
);

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    TRACE  = 3'b001,
    REMOTE = 3'b010
`ifdef AVOID_EN
    ,
    BACKUP = 3'b011,
    TURN   = 3'b100
`endif
  } state_e;

  typedef enum logic [2:0] {
    DRV_STOP,
    DRV_FWD,
    DRV_BACK,
    DRV_LEFT,
    DRV_RIGHT,
    DRV_PIVL,
    DRV_PIVR
  } drive_e;

  typedef struct packed {
    logic [1:0] w1;
    logic [1:0] w2;
    logic [1:0] s1;
    logic [1:0] s2;
    logic [3:0] led;
  } drive_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(REMOTE_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
`ifdef AVOID_EN
  localparam logic [CNT_W-1:0] BACKUP_LAST = CNT_W'(BACKUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TURN_LAST   = CNT_W'(TURN_CYCLES - 1);
`endif

  function automatic drive_t patternOf(input drive_e d);
    drive_t p;
    p = '0;
    case (d)
      DRV_FWD:   p = '{w1: 2'b10, w2: 2'b10, s1: 2'b11, s2: 2'b11, led: 4'b0001};
      DRV_BACK:  p = '{w1: 2'b01, w2: 2'b01, s1: 2'b01, s2: 2'b01, led: 4'b0010};
      DRV_LEFT:  p = '{w1: 2'b10, w2: 2'b10, s1: 2'b01, s2: 2'b10, led: 4'b0100};
      DRV_RIGHT: p = '{w1: 2'b10, w2: 2'b10, s1: 2'b10, s2: 2'b01, led: 4'b1000};
      DRV_PIVL:  p = '{w1: 2'b01, w2: 2'b10, s1: 2'b10, s2: 2'b10, led: 4'b0100};
      DRV_PIVR:  p = '{w1: 2'b10, w2: 2'b01, s1: 2'b10, s2: 2'b10, led: 4'b1000};
      default:   p = '0;
    endcase
    return p;
  endfunction

  function automatic drive_e traceDrive(input logic [1:0] c);
    drive_e d;
    case (c)
      2'b01:   d = DRV_FWD;
      2'b10:   d = DRV_LEFT;
      2'b11:   d = DRV_RIGHT;
      default: d = DRV_STOP;
    endcase
    return d;
  endfunction

  function automatic drive_e remoteDrive(input logic [2:0] c);
    drive_e d;
    case (c)
      3'b001:  d = DRV_FWD;
      3'b010:  d = DRV_BACK;
      3'b011:  d = DRV_LEFT;
      3'b100:  d = DRV_RIGHT;
      default: d = DRV_STOP;
    endcase
    return d;
  endfunction

  state_e           state_q, state_d;
  logic [2:0]       cmd_q, cmd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  drive_t           drive_q, drive_d;
  drive_e           driveSel;
  logic             rcOk;

  assign rcOk = rc_valid && (rc_cmd <= 3'd4);

`ifdef AVOID_EN
  logic side_q, side_d;
  logic trigger;

  // Reverse commands are excluded: backing away from a sensed obstacle is harmless.
  assign trigger = (AvoidSignal != 2'b00) &&
                   (((state_q == TRACE) && (trace_cmd != 2'b00)) ||
                    ((state_q == REMOTE) &&
                     ((cmd_q == 3'b001) || (cmd_q == 3'b011) || (cmd_q == 3'b100))));
`else
  logic unused_avoid;
  assign unused_avoid = ^{AvoidSignal, BACKUP_CYCLES[0], TURN_CYCLES[0]};
`endif

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    cnt_d   = cnt_q;
`ifdef AVOID_EN
    side_d  = side_q;
`endif
    case (state_q)
      IDLE: begin
        if (rcOk) begin
          state_d = REMOTE;
          cmd_d   = rc_cmd;
        end else if (En_Tracing) begin
          state_d = TRACE;
        end
      end
      TRACE: begin
`ifdef AVOID_EN
        if (trigger) begin
          state_d = BACKUP;
          side_d  = (AvoidSignal == 2'b01);
        end else
`endif
        if (rcOk) begin
          state_d = REMOTE;
          cmd_d   = rc_cmd;
        end else if (!En_Tracing) begin
          state_d = IDLE;
        end
      end
      REMOTE: begin
`ifdef AVOID_EN
        if (trigger) begin
          state_d = BACKUP;
          side_d  = (AvoidSignal == 2'b01);
        end else
`endif
        if (rcOk) begin
          cmd_d = rc_cmd;
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = En_Tracing ? TRACE : IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
`ifdef AVOID_EN
      BACKUP: begin
        if (cnt_q == BACKUP_LAST) state_d = TURN;
        else cnt_d = cnt_q + CNT_ONE;
      end
      TURN: begin
        if (cnt_q == TURN_LAST) state_d = En_Tracing ? TRACE : IDLE;
        else cnt_d = cnt_q + CNT_ONE;
      end
`endif
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // Drive pattern is decoded from next-state values so it lands on the same edge as mode.
  always_comb begin
    driveSel = DRV_STOP;
    case (state_d)
      TRACE:  driveSel = traceDrive(trace_cmd);
      REMOTE: driveSel = remoteDrive(cmd_d);
`ifdef AVOID_EN
      BACKUP: driveSel = DRV_BACK;
      TURN:   driveSel = side_d ? DRV_PIVR : DRV_PIVL;
`endif
      default: driveSel = DRV_STOP;
    endcase
    drive_d = patternOf(driveSel);
  end

  always_ff @(posedge clk) begin
    if (CR) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      cnt_q   <= '0;
      drive_q <= '0;
`ifdef AVOID_EN
      side_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
      drive_q <= drive_d;
`ifdef AVOID_EN
      side_q  <= side_d;
`endif
    end
  end

  assign Control_Wheel_1 = drive_q.w1;
  assign Control_Wheel_2 = drive_q.w2;
  assign spd_sel_1       = drive_q.s1;
  assign spd_sel_2       = drive_q.s2;
  assign Led_Direction   = drive_q.led;
  assign mode            = state_q;

endmodule

// File: tb/tb_drive_arbiter.sv
// tb_drive_arbiter: directed vector table plus hand-written manoeuvre sequences for drive_arbiter,
// using short manoeuvre/hold lengths so every timed exit is reached quickly.
module tb_drive_arbiter;

  localparam int unsigned BACKUP_CYCLES = 4;
  localparam int unsigned TURN_CYCLES   = 3;
  localparam int unsigned REMOTE_HOLD   = 6;
  localparam int unsigned CNT_W         = 27;

  localparam logic [2:0] M_IDLE   = 3'b000;
  localparam logic [2:0] M_TRACE  = 3'b001;
  localparam logic [2:0] M_REMOTE = 3'b010;
  localparam logic [2:0] M_BACKUP = 3'b011;
  localparam logic [2:0] M_TURN   = 3'b100;

  // Drive patterns packed as {wheel1, wheel2, spd1, spd2, led}
  localparam logic [11:0] P_STOP  = 12'b0;
  localparam logic [11:0] P_FWD   = {2'b10, 2'b10, 2'b11, 2'b11, 4'b0001};
  localparam logic [11:0] P_BACK  = {2'b01, 2'b01, 2'b01, 2'b01, 4'b0010};
  localparam logic [11:0] P_LEFT  = {2'b10, 2'b10, 2'b01, 2'b10, 4'b0100};
  localparam logic [11:0] P_RIGHT = {2'b10, 2'b10, 2'b10, 2'b01, 4'b1000};
  localparam logic [11:0] P_PIVL  = {2'b01, 2'b10, 2'b10, 2'b10, 4'b0100};
  localparam logic [11:0] P_PIVR  = {2'b10, 2'b01, 2'b10, 2'b10, 4'b1000};

  logic       clk = 1'b0;
  logic       CR;
  logic       En_Tracing;
  logic [1:0] trace_cmd;
  logic       rc_valid;
  logic [2:0] rc_cmd;
  logic [1:0] AvoidSignal;
  logic [1:0] Control_Wheel_1;
  logic [1:0] Control_Wheel_2;
  logic [1:0] spd_sel_1;
  logic [1:0] spd_sel_2;
  logic [3:0] Led_Direction;
  logic [2:0] mode;

  always #5 clk = ~clk;

  drive_arbiter #(
    .BACKUP_CYCLES(BACKUP_CYCLES),
    .TURN_CYCLES  (TURN_CYCLES),
    .REMOTE_HOLD  (REMOTE_HOLD),
    .CNT_W        (CNT_W)
  ) dut (
    .clk            (clk),
    .CR             (CR),
    .En_Tracing     (En_Tracing),
    .trace_cmd      (trace_cmd),
    .rc_valid       (rc_valid),
    .rc_cmd         (rc_cmd),
    .AvoidSignal    (AvoidSignal),
    .Control_Wheel_1(Control_Wheel_1),
    .Control_Wheel_2(Control_Wheel_2),
    .spd_sel_1      (spd_sel_1),
    .spd_sel_2      (spd_sel_2),
    .Led_Direction  (Led_Direction),
    .mode           (mode)
  );

  typedef struct packed {
    logic        cr;
    logic        en;
    logic [1:0]  tcmd;
    logic        rcv;
    logic [2:0]  rccmd;
    logic [1:0]  avoid;
    logic [2:0]  expMode;
    logic [11:0] expDrive;
  } vec_t;

  vec_t vecs[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic addVec(input logic cr, input logic en, input logic [1:0] tcmd,
                        input logic rcv, input logic [2:0] rccmd, input logic [1:0] avoid,
                        input logic [2:0] expMode, input logic [11:0] expDrive);
    vec_t v;
    v = '{cr: cr, en: en, tcmd: tcmd, rcv: rcv, rccmd: rccmd, avoid: avoid,
          expMode: expMode, expDrive: expDrive};
    vecs.push_back(v);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic applyStimulus(input logic cr, input logic en, input logic [1:0] tcmd,
                               input logic rcv, input logic [2:0] rccmd, input logic [1:0] avoid);
    @(negedge clk);
    CR          = cr;
    En_Tracing  = en;
    trace_cmd   = tcmd;
    rc_valid    = rcv;
    rc_cmd      = rccmd;
    AvoidSignal = avoid;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [2:0] expMode,
                             input logic [11:0] expDrive);
    logic [11:0] actual;
    actual = {Control_Wheel_1, Control_Wheel_2, spd_sel_1, spd_sel_2, Led_Direction};
    vectors++;
    if (mode !== expMode || actual !== expDrive) begin
      miscompares++;
      $display("[TB] FAIL %s: got mode=%b drive=%b, expected mode=%b drive=%b",
               name, mode, actual, expMode, expDrive);
    end
  endtask

  task automatic step(input string name, input logic cr, input logic en, input logic [1:0] tcmd,
                      input logic rcv, input logic [2:0] rccmd, input logic [1:0] avoid,
                      input logic [2:0] expMode, input logic [11:0] expDrive);
    applyStimulus(cr, en, tcmd, rcv, rccmd, avoid);
    checkOutput(name, expMode, expDrive);
  endtask

  initial begin
    CR = 1'b1;
    En_Tracing = 1'b0;
    trace_cmd = 2'b00;
    rc_valid = 1'b0;
    rc_cmd = 3'b000;
    AvoidSignal = 2'b00;

    // Reset, tracer patterns, remote latch/hold behaviour
    addVec(1, 0, 2'b00, 0, 3'b000, 2'b00, M_IDLE,   P_STOP);
    addVec(1, 0, 2'b00, 0, 3'b000, 2'b00, M_IDLE,   P_STOP);
    addVec(0, 1, 2'b10, 0, 3'b000, 2'b00, M_TRACE,  P_LEFT);
    addVec(0, 1, 2'b01, 0, 3'b000, 2'b00, M_TRACE,  P_FWD);
    addVec(0, 1, 2'b11, 0, 3'b000, 2'b00, M_TRACE,  P_RIGHT);
    addVec(0, 1, 2'b00, 0, 3'b000, 2'b00, M_TRACE,  P_STOP);
    addVec(0, 0, 2'b00, 0, 3'b000, 2'b00, M_IDLE,   P_STOP);
    addVec(0, 0, 2'b00, 1, 3'b011, 2'b00, M_REMOTE, P_LEFT);
    addVec(0, 0, 2'b00, 0, 3'b000, 2'b00, M_REMOTE, P_LEFT);
    addVec(0, 0, 2'b00, 1, 3'b111, 2'b00, M_REMOTE, P_LEFT);
    addVec(0, 1, 2'b01, 1, 3'b100, 2'b00, M_REMOTE, P_RIGHT);
    addVec(0, 1, 2'b01, 0, 3'b000, 2'b00, M_REMOTE, P_RIGHT);
    addVec(0, 1, 2'b01, 1, 3'b111, 2'b00, M_REMOTE, P_RIGHT);
    addVec(0, 1, 2'b01, 0, 3'b000, 2'b00, M_REMOTE, P_RIGHT);
    addVec(0, 1, 2'b01, 1, 3'b110, 2'b00, M_REMOTE, P_RIGHT);
    addVec(0, 1, 2'b01, 0, 3'b000, 2'b00, M_REMOTE, P_RIGHT);
    addVec(0, 1, 2'b01, 0, 3'b000, 2'b00, M_TRACE,  P_FWD);
    addVec(0, 1, 2'b01, 1, 3'b010, 2'b00, M_REMOTE, P_BACK);
    for (int i = 0; i < 5; i++)
      addVec(0, 0, 2'b00, 0, 3'b000, 2'b11, M_REMOTE, P_BACK);
    addVec(0, 0, 2'b00, 1, 3'b000, 2'b00, M_REMOTE, P_STOP);
    for (int i = 0; i < 5; i++)
      addVec(0, 0, 2'b00, 0, 3'b000, 2'b00, M_REMOTE, P_STOP);
    addVec(0, 0, 2'b00, 0, 3'b000, 2'b00, M_IDLE,   P_STOP);
    addVec(0, 0, 2'b00, 1, 3'b101, 2'b00, M_IDLE,   P_STOP);
    addVec(0, 1, 2'b01, 0, 3'b000, 2'b11, M_TRACE,  P_FWD);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].cr, vecs[i].en, vecs[i].tcmd, vecs[i].rcv, vecs[i].rccmd,
                    vecs[i].avoid);
      checkOutput($sformatf("vec%0d", i), vecs[i].expMode, vecs[i].expDrive);
    end

`ifdef AVOID_EN
    // Tracer forward, one-cycle right-side hit: 4 cycles back, 3 cycles pivot right
    step("bk_enter", 0, 1, 2'b01, 0, 3'b000, 2'b01, M_BACKUP, P_BACK);
    step("bk_rcdrop", 0, 1, 2'b01, 1, 3'b001, 2'b00, M_BACKUP, P_BACK);
    for (int i = 0; i < 2; i++)
      step($sformatf("bk_hold%0d", i), 0, 1, 2'b01, 0, 3'b000, 2'b00, M_BACKUP, P_BACK);
    for (int i = 0; i < 3; i++)
      step($sformatf("turn_r%0d", i), 0, 1, 2'b01, 0, 3'b000, 2'b00, M_TURN, P_PIVR);
    step("turn_exit", 0, 1, 2'b01, 0, 3'b000, 2'b00, M_TRACE, P_FWD);
    // Remote strobe on the trigger edge is lost; left-side hit pivots left
    step("bk_vs_rc", 0, 1, 2'b01, 1, 3'b001, 2'b10, M_BACKUP, P_BACK);
    for (int i = 0; i < 3; i++)
      step($sformatf("bk2_hold%0d", i), 0, 0, 2'b00, 0, 3'b000, 2'b00, M_BACKUP, P_BACK);
    step("turn_l", 0, 0, 2'b00, 0, 3'b000, 2'b00, M_TURN, P_PIVL);
    step("cr_turn0", 1, 0, 2'b00, 0, 3'b000, 2'b00, M_IDLE, P_STOP);
    step("cr_turn1", 1, 0, 2'b00, 0, 3'b000, 2'b00, M_IDLE, P_STOP);
    step("post_cr", 0, 0, 2'b00, 0, 3'b000, 2'b00, M_IDLE, P_STOP);
    // Remote left is interrupted by an obstacle
    step("rem_left", 0, 0, 2'b00, 1, 3'b011, 2'b00, M_REMOTE, P_LEFT);
    step("rem_trig", 0, 0, 2'b00, 0, 3'b000, 2'b01, M_BACKUP, P_BACK);
    for (int i = 0; i < 3; i++)
      step($sformatf("bk3_hold%0d", i), 0, 1, 2'b00, 0, 3'b000, 2'b00, M_BACKUP, P_BACK);
    for (int i = 0; i < 3; i++)
      step($sformatf("turn3_r%0d", i), 0, 0, 2'b00, 0, 3'b000, 2'b00, M_TURN, P_PIVR);
    step("turn3_exit", 0, 0, 2'b00, 0, 3'b000, 2'b00, M_IDLE, P_STOP);
`else
    // Without avoidance the sensors never pre-empt tracer or remote
    for (int i = 0; i < 4; i++)
      step($sformatf("noavoid_tr%0d", i), 0, 1, 2'b01, 0, 3'b000, 2'b11, M_TRACE, P_FWD);
    step("noavoid_rc", 0, 1, 2'b01, 1, 3'b001, 2'b11, M_REMOTE, P_FWD);
    step("noavoid_rem", 0, 1, 2'b01, 0, 3'b000, 2'b01, M_REMOTE, P_FWD);
    step("cr_remote", 1, 1, 2'b01, 0, 3'b000, 2'b00, M_IDLE, P_STOP);
    step("post_cr", 0, 0, 2'b01, 1, 3'b100, 2'b00, M_REMOTE, P_RIGHT);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
